pwm_spi_regfile: RTL and testbench

Byte-level command decoder and register bank between the SPI slave byte interface and the 3-channel PWM core. It parses command/data byte frames from rx_dv/rx_byte and holds the PWM configuration registers: period, prescaler, three duty cycles and enable. It serves read-back bytes to the SPI slave through tx_dv/tx_byte. All register outputs feed the PWM core directly.

---
 rtl/pwm_regs_pkg.sv | 38 +++
 rtl/pwm_spi_regfile_if.sv | 19 +
 rtl/pwm_spi_regfile_fsm.sv | 142 ++++++++++++++
 rtl/pwm_spi_regfile.sv | 152 +++++++++++++++
 tb/tb_pwm_spi_regfile.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_regs_pkg.sv
// Shared definitions for the PWM configuration register bank:
// register addresses, command byte layout, frame FSM states and reset values.
package pwm_regs_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam logic [31:0] PERIOD_RST_DEF = 32'h0000_00FF;
    localparam logic [31:0] REG_RST_DEF    = 32'h0000_0000;

    localparam logic [2:0] ADDR_PERIOD  = 3'd0;
    localparam logic [2:0] ADDR_PRESC   = 3'd1;
    localparam logic [2:0] ADDR_DUTY1   = 3'd2;
    localparam logic [2:0] ADDR_DUTY2   = 3'd3;
    localparam logic [2:0] ADDR_DUTY3   = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;
    localparam logic [2:0] ADDR_INVALID = 3'd7;

    localparam int unsigned CMD_WR_BIT  = 7;
    localparam int unsigned CMD_RSVD_HI = 6;
    localparam int unsigned CMD_RSVD_LO = 3;
    localparam int unsigned CMD_ADDR_HI = 2;
    localparam int unsigned CMD_ADDR_LO = 0;

    // Command byte layout, MSB first: write flag, reserved nibble, address.
    typedef struct packed {
        logic       wr;
        logic [3:0] rsvd;
        logic [2:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WDATA   = 2'd1,
        ST_RDATA   = 2'd2,
        ST_DISCARD = 2'd3
    } frame_state_t;

endpackage

// File: rtl/pwm_spi_regfile_if.sv
// Byte-level link between the SPI slave and the register bank.
//   cs_n    : chip select, synchronised, 1 = idle
//   rx_dv   : one-cycle strobe, rx_byte valid
//   rx_byte : byte received on MOSI
//   tx_dv   : one-cycle strobe, load tx_byte into the SPI slave
//   tx_byte : next byte to shift out on MISO
interface pwm_spi_regfile_if;
    logic       cs_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;

    // master: the SPI slave shifter side; slave: the register bank side
    modport master (output cs_n, output rx_dv, output rx_byte,
                    input  tx_dv, input  tx_byte);
    modport slave  (input  cs_n, input  rx_dv, input  rx_byte,
                    output tx_dv, output tx_byte);
endinterface

// File: rtl/pwm_spi_regfile_fsm.sv
// spi_frame_fsm: parses command/data byte frames, counts data bytes,
// stages write data and emits commit / read-select / transmit strobes.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   i_cs_n            : chip select (1 aborts the frame)
//   i_rx_dv, i_rx_byte: received byte strobe and value
//   o_wr_commit_c     : commit o_wr_data_c to register o_wr_addr this cycle
//   o_wr_addr         : target address of the write in progress
//   o_wr_data_c       : staged data including the current byte
//   o_rd_sel_c        : take a read snapshot of register o_rd_addr_c
//   o_tx_req_c        : load tx byte from lane o_tx_lane_c next cycle
//   o_frame_err_c     : set the sticky frame-error flag
module spi_frame_fsm
    import pwm_regs_pkg::*;
#(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cs_n,
    input  logic                  i_rx_dv,
    input  logic [7:0]            i_rx_byte,
    output logic                  o_wr_commit_c,
    output logic [2:0]            o_wr_addr,
    output logic [8*NBYTES-1:0]   o_wr_data_c,
    output logic                  o_rd_sel_c,
    output logic [2:0]            o_rd_addr_c,
    output logic                  o_tx_req_c,
    output logic [CNT_W-1:0]      o_tx_lane_c,
    output logic                  o_frame_err_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    frame_state_t          r_state;
    frame_state_t          w_state_nxt;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [CNT_W-1:0]      w_byte_cnt_nxt;
    logic [8*NBYTES-1:0]   r_stage;
    logic [8*NBYTES-1:0]   w_stage_nxt;
    logic [8*NBYTES-1:0]   w_merged;
    logic [2:0]            r_addr;
    logic [2:0]            w_addr_nxt;
    cmd_t                  w_cmd;

    assign w_cmd       = cmd_t'(i_rx_byte);
    assign o_wr_addr   = r_addr;
    assign o_wr_data_c = w_merged;
    assign o_rd_addr_c = w_cmd.addr;

    // Staging value with the current byte dropped into lane byte_cnt
    always_comb begin
        w_merged = r_stage;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (CNT_W'(i) == r_byte_cnt) begin
                w_merged[8*i +: 8] = i_rx_byte;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_stage    <= '0;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_stage    <= w_stage_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    // Next state and strobes; cs_n high overrides any byte in the same cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_stage_nxt    = r_stage;
        w_addr_nxt     = r_addr;
        o_wr_commit_c  = 1'b0;
        o_rd_sel_c     = 1'b0;
        o_tx_req_c     = 1'b0;
        o_tx_lane_c    = '0;
        o_frame_err_c  = 1'b0;

        if (i_cs_n) begin
            w_state_nxt    = ST_IDLE;
            w_byte_cnt_nxt = '0;
            w_stage_nxt    = '0;
        end else if (i_rx_dv) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_byte_cnt_nxt = '0;
                    if ((w_cmd.rsvd != 4'd0) || (w_cmd.addr == ADDR_INVALID)) begin
                        w_state_nxt   = ST_DISCARD;
                        o_frame_err_c = 1'b1;
                    end else if (w_cmd.wr) begin
                        w_state_nxt = ST_WDATA;
                        w_stage_nxt = '0;
                        w_addr_nxt  = w_cmd.addr;
                    end else begin
                        w_state_nxt = ST_RDATA;
                        o_rd_sel_c  = 1'b1;
                        o_tx_req_c  = 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (r_byte_cnt == CNT_LAST) begin
                        o_wr_commit_c  = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_byte_cnt_nxt = '0;
                        w_stage_nxt    = '0;
                    end else begin
                        w_stage_nxt    = w_merged;
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end
                ST_RDATA: begin
                    // last dummy byte closes the read without a transmit
                    if (r_byte_cnt == CNT_LAST) begin
                        w_state_nxt    = ST_IDLE;
                        w_byte_cnt_nxt = '0;
                    end else begin
                        o_tx_req_c     = 1'b1;
                        o_tx_lane_c    = r_byte_cnt + 1'b1;
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end
                ST_DISCARD: begin
                    w_state_nxt = ST_DISCARD;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_spi_regfile.sv
// pwm_spi_regfile: PWM configuration register bank behind the SPI byte link.
// Holds period, prescaler, three duties, CTRL (enable) and STATUS (sticky
// frame error), commits writes atomically and serves coherent read-back.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   spi                        : byte link (cs_n, rx_dv, rx_byte, tx_dv, tx_byte)
//   counter_value, prescaler   : PWM period and clock prescaler
//   duty_cycle_1..3            : channel duty cycles
//   enable_pwm                 : CTRL bit0
module pwm_spi_regfile
    import pwm_regs_pkg::*;
#(
    parameter int unsigned          DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0]    PERIOD_RST = DATA_W'(PERIOD_RST_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_spi_regfile_if.slave     spi,
    output logic [DATA_W-1:0]    counter_value,
    output logic [DATA_W-1:0]    prescaler,
    output logic [DATA_W-1:0]    duty_cycle_1,
    output logic [DATA_W-1:0]    duty_cycle_2,
    output logic [DATA_W-1:0]    duty_cycle_3,
    output logic                 enable_pwm
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_W-1:0] r_period;
    logic [DATA_W-1:0] r_presc;
    logic [DATA_W-1:0] r_duty1;
    logic [DATA_W-1:0] r_duty2;
    logic [DATA_W-1:0] r_duty3;
    logic [7:0]        r_ctrl;
    logic              r_err;
    logic [DATA_W-1:0] r_snap;
    logic              r_tx_dv;
    logic [7:0]        r_tx_byte;

    logic              w_wr_commit;
    logic [2:0]        w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_rd_sel;
    logic [2:0]        w_rd_addr;
    logic              w_tx_req;
    logic [CNT_W-1:0]  w_tx_lane;
    logic              w_frame_err;
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] w_tx_src;
    logic [7:0]        w_tx_byte;

    spi_frame_fsm #(
        .NBYTES (NBYTES)
    ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cs_n        (spi.cs_n),
        .i_rx_dv       (spi.rx_dv),
        .i_rx_byte     (spi.rx_byte),
        .o_wr_commit_c (w_wr_commit),
        .o_wr_addr     (w_wr_addr),
        .o_wr_data_c   (w_wr_data),
        .o_rd_sel_c    (w_rd_sel),
        .o_rd_addr_c   (w_rd_addr),
        .o_tx_req_c    (w_tx_req),
        .o_tx_lane_c   (w_tx_lane),
        .o_frame_err_c (w_frame_err)
    );

    // Read mux; CTRL and STATUS read back zero-extended
    always_comb begin
        w_rd_mux = '0;
        unique case (w_rd_addr)
            ADDR_PERIOD: w_rd_mux = r_period;
            ADDR_PRESC:  w_rd_mux = r_presc;
            ADDR_DUTY1:  w_rd_mux = r_duty1;
            ADDR_DUTY2:  w_rd_mux = r_duty2;
            ADDR_DUTY3:  w_rd_mux = r_duty3;
            ADDR_CTRL:   w_rd_mux = DATA_W'(r_ctrl);
            ADDR_STATUS: w_rd_mux = DATA_W'(r_err);
            default:     w_rd_mux = '0;
        endcase
    end

    // Byte 0 comes straight from the mux because the snapshot lands this edge
    always_comb begin
        w_tx_src  = w_rd_sel ? w_rd_mux : r_snap;
        w_tx_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (CNT_W'(i) == w_tx_lane) begin
                w_tx_byte = w_tx_src[8*i +: 8];
            end
        end
    end

    // Register bank: whole-word commit, W1C on STATUS bit0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= PERIOD_RST;
            r_presc  <= '0;
            r_duty1  <= '0;
            r_duty2  <= '0;
            r_duty3  <= '0;
            r_ctrl   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_commit) begin
                unique case (w_wr_addr)
                    ADDR_PERIOD: r_period <= w_wr_data;
                    ADDR_PRESC:  r_presc  <= w_wr_data;
                    ADDR_DUTY1:  r_duty1  <= w_wr_data;
                    ADDR_DUTY2:  r_duty2  <= w_wr_data;
                    ADDR_DUTY3:  r_duty3  <= w_wr_data;
                    ADDR_CTRL:   r_ctrl   <= w_wr_data[7:0];
                    ADDR_STATUS: if (w_wr_data[0]) r_err <= 1'b0;
                    default: ;
                endcase
            end
            if (w_frame_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read snapshot and transmit byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap    <= '0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
        end else begin
            r_tx_dv <= w_tx_req;
            if (w_rd_sel) begin
                r_snap <= w_rd_mux;
            end
            if (w_tx_req) begin
                r_tx_byte <= w_tx_byte;
            end
        end
    end

    assign spi.tx_dv     = r_tx_dv;
    assign spi.tx_byte   = r_tx_byte;
    assign counter_value = r_period;
    assign prescaler     = r_presc;
    assign duty_cycle_1  = r_duty1;
    assign duty_cycle_2  = r_duty2;
    assign duty_cycle_3  = r_duty3;
    assign enable_pwm    = r_ctrl[0];

endmodule

// File: tb/tb_pwm_spi_regfile.sv
// Directed table-driven bench for pwm_spi_regfile: each record is one bus
// cycle (cs_n, rx_dv, rx_byte) with the expected tx response and an optional
// expected register value one cycle later.
module tb_pwm_spi_regfile;

    logic clk;
    logic rst_n;

    logic [31:0] counter_value;
    logic [31:0] prescaler;
    logic [31:0] duty_cycle_1;
    logic [31:0] duty_cycle_2;
    logic [31:0] duty_cycle_3;
    logic        enable_pwm;

    int n_checks;
    int n_errors;

    pwm_spi_regfile_if spi_if ();

    pwm_spi_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi           (spi_if),
        .counter_value (counter_value),
        .prescaler     (prescaler),
        .duty_cycle_1  (duty_cycle_1),
        .duty_cycle_2  (duty_cycle_2),
        .duty_cycle_3  (duty_cycle_3),
        .enable_pwm    (enable_pwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 period, 1 prescaler, 2..4 duty 1..3, 5 enable, 7 no register check
    typedef struct {
        logic        cs_n;
        logic        rx_dv;
        logic [7:0]  b;
        logic        exp_tx;
        logic [7:0]  exp_byte;
        logic [2:0]  sel;
        logic [31:0] exp_val;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic cs, input logic dv, input logic [7:0] b,
                                input logic etx, input logic [7:0] eb,
                                input logic [2:0] sel, input logic [31:0] ev);
        vec_t v;
        v.cs_n = cs; v.rx_dv = dv; v.b = b; v.exp_tx = etx; v.exp_byte = eb;
        v.sel = sel; v.exp_val = ev;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] sel);
        case (sel)
            3'd0:    return counter_value;
            3'd1:    return prescaler;
            3'd2:    return duty_cycle_1;
            3'd3:    return duty_cycle_2;
            3'd4:    return duty_cycle_3;
            3'd5:    return {31'd0, enable_pwm};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle of stimulus, then one quiet cycle (cs_n low, no byte)
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        spi_if.cs_n    = v.cs_n;
        spi_if.rx_dv   = v.rx_dv;
        spi_if.rx_byte = v.b;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_tx_dv", idx), {31'd0, spi_if.tx_dv}, {31'd0, v.exp_tx});
        if (v.exp_tx)
            chk($sformatf("v%0d_tx_byte", idx), {24'd0, spi_if.tx_byte}, {24'd0, v.exp_byte});
        if (v.sel != 3'd7)
            chk($sformatf("v%0d_reg%0d", idx, v.sel), reg_val(v.sel), v.exp_val);
        spi_if.rx_dv = 1'b0;
        spi_if.cs_n  = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_tx_dv_single", idx), {31'd0, spi_if.tx_dv}, 32'd0);
    endtask

    task automatic read4(input logic [7:0] cmd, input logic [31:0] val);
        add(0, 1, cmd,   1, val[7:0],   7, 0);
        add(0, 1, 8'h00, 1, val[15:8],  7, 0);
        add(0, 1, 8'h00, 1, val[23:16], 7, 0);
        add(0, 1, 8'h00, 1, val[31:24], 7, 0);
        add(0, 1, 8'h00, 0, 8'h00,      7, 0);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        spi_if.cs_n    = 1'b1;
        spi_if.rx_dv   = 1'b0;
        spi_if.rx_byte = 8'h00;

        // Read addr 0 after reset
        add(0, 1, 8'h00, 1, 8'hFF, 0, 32'hFF);
        add(0, 1, 8'h00, 1, 8'h00, 1, 0);
        add(0, 1, 8'h00, 1, 8'h00, 2, 0);
        add(0, 1, 8'h00, 1, 8'h00, 4, 0);
        add(0, 1, 8'h00, 0, 8'h00, 5, 0);
        add(1, 0, 8'h00, 0, 8'h00, 3, 0);
        // Write duty1 = 0x1234, invisible until the last byte
        add(0, 1, 8'h82, 0, 0, 2, 0);
        add(0, 1, 8'h34, 0, 0, 2, 0);
        add(0, 1, 8'h12, 0, 0, 2, 0);
        add(0, 1, 8'h00, 0, 0, 2, 0);
        add(0, 1, 8'h00, 0, 0, 2, 32'h1234);
        // Write CTRL = 1 in the same frame, then read it back
        add(0, 1, 8'h85, 0, 0, 5, 0);
        add(0, 1, 8'h01, 0, 0, 5, 0);
        add(0, 1, 8'h00, 0, 0, 5, 0);
        add(0, 1, 8'h00, 0, 0, 5, 0);
        add(0, 1, 8'h00, 0, 0, 5, 1);
        read4(8'h05, 32'h01);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        // Partial write of duty2 aborted by cs_n
        add(0, 1, 8'h83, 0, 0, 3, 0);
        add(0, 1, 8'hAA, 0, 0, 3, 0);
        add(0, 1, 8'hBB, 0, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 3, 0);
        read4(8'h06, 32'h00);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        // Invalid address: following bytes discarded, error flag set
        add(0, 1, 8'h87, 0, 0, 5, 1);
        add(0, 1, 8'h85, 0, 0, 5, 1);
        add(0, 1, 8'h00, 0, 0, 5, 1);
        add(0, 1, 8'h00, 0, 0, 5, 1);
        add(0, 1, 8'h00, 0, 0, 5, 1);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        read4(8'h06, 32'h01);
        // W1C the error flag, read it back cleared
        add(0, 1, 8'h86, 0, 0, 7, 0);
        add(0, 1, 8'h01, 0, 0, 7, 0);
        add(0, 1, 8'h00, 0, 0, 7, 0);
        add(0, 1, 8'h00, 0, 0, 7, 0);
        add(0, 1, 8'h00, 0, 0, 7, 0);
        read4(8'h06, 32'h00);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        // Reserved bits set also discard
        add(0, 1, 8'h08, 0, 0, 7, 0);
        add(0, 1, 8'h00, 0, 0, 7, 0);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        read4(8'h06, 32'h01);
        add(1, 0, 8'h00, 0, 0, 7, 0);
        // Back-to-back writes in one frame
        add(0, 1, 8'h80, 0, 0, 0, 32'hFF);
        add(0, 1, 8'h64, 0, 0, 0, 32'hFF);
        add(0, 1, 8'h00, 0, 0, 0, 32'hFF);
        add(0, 1, 8'h00, 0, 0, 0, 32'hFF);
        add(0, 1, 8'h00, 0, 0, 0, 32'h64);
        add(0, 1, 8'h81, 0, 0, 1, 0);
        add(0, 1, 8'h03, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 1, 32'h3);
        // Byte coincident with cs_n high is dropped; next byte is a fresh command
        add(1, 1, 8'h80, 0, 0, 0, 32'h64);
        read4(8'h01, 32'h03);
        add(1, 0, 8'h00, 0, 0, 7, 0);

        // Reset state
        #12;
        chk("rst_period",  counter_value, 32'hFF);
        chk("rst_presc",   prescaler, 0);
        chk("rst_duty1",   duty_cycle_1, 0);
        chk("rst_duty2",   duty_cycle_2, 0);
        chk("rst_duty3",   duty_cycle_3, 0);
        chk("rst_enable",  {31'd0, enable_pwm}, 0);
        chk("rst_tx_dv",   {31'd0, spi_if.tx_dv}, 0);
        chk("rst_tx_byte", {24'd0, spi_if.tx_byte}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset in the middle of a read frame
        v.cs_n = 0; v.rx_dv = 1; v.b = 8'h00; v.exp_tx = 1; v.exp_byte = 8'h64;
        v.sel = 5; v.exp_val = 1;
        apply(v, 1000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_period",  counter_value, 32'hFF);
        chk("arst_presc",   prescaler, 0);
        chk("arst_duty1",   duty_cycle_1, 32'h0);
        chk("arst_enable",  {31'd0, enable_pwm}, 0);
        chk("arst_tx_byte", {24'd0, spi_if.tx_byte}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // FSM back in IDLE: a new read command is parsed, not counted as dummy
        v.exp_byte = 8'hFF; v.sel = 0; v.exp_val = 32'hFF;
        apply(v, 1001);
        v.exp_byte = 8'h00; v.sel = 7;
        apply(v, 1002);
        @(negedge clk);
        spi_if.cs_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
